if_id_pipe_reg: RTL and testbench
=================================

Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline register carrying a fetched instruction and its PC from fetch to decode. It uses a valid/ready handshake so decode can stall fetch, and a synchronous flush for branch redirects. SKID=1 adds a second entry, so in_ready comes from a flop and does not depend combinationally on out_ready. Invalid slots present a NOP bubble to decode.

Parameters:
INSTR_W, 32, instruction width
PC_W, 32, PC width
SKID, 1, 0 = single-entry register; 1 = main entry plus skid entry
NOP_INSTR, 32'h0000_0000, value on out_instr when out_valid=0 (INSTR_W bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  register accepts this cycle
in_instr  in  INSTR_W  fetched instruction
in_pc  in  PC_W  PC of in_instr
flush  in  1  synchronous kill of all held and incoming entries
out_valid  out  1  decode-side instruction valid
out_ready  in  1  decode consumes this cycle (0 = stall)
out_instr  out  INSTR_W  instruction to decode; NOP_INSTR when out_valid=0
out_pc  out  PC_W  PC of out_instr; 0 when out_valid=0
occ  out  2  entries held (0..1 for SKID=0, 0..2 for SKID=1)

Behaviour:
Handshake definitions:
- push = in_valid & in_ready & !flush
- pop = out_valid & out_ready

Reset (rst_n=0, asynchronous):
- out_valid=0, out_instr=NOP_INSTR, out_pc=0, occ=0.
- All entries are cleared; in_ready=1 as soon as reset releases.

Ordering and stability:
- Strict in-order delivery; no entry is duplicated or dropped except by flush.
- While out_valid=1 and out_ready=0, out_instr and out_pc hold stable cycle to cycle.

Latency:
- An accepted instruction appears on out_* on the next rising edge when the register was empty, or after being popped through.
- No combinational path from in_* to out_*.

SKID=0 (one entry):
- in_ready = !out_valid | out_ready. This is combinational from out_ready, which is allowed in this mode only.
- Edge with push: load in_instr/in_pc; out_valid=1.
- Edge with pop and no push: out_valid=0.

SKID=1 (states EMPTY, ONE, FULL; occ = 0, 1, 2):
- in_ready = (state != FULL), driven directly from the state flops.
- EMPTY: push -> ONE; the entry loads into main.
- ONE, push & pop -> ONE; main takes the new entry.
- ONE, push & !pop -> FULL; the new entry goes to skid.
- ONE, !push & pop -> EMPTY.
- ONE, neither -> hold.
- FULL: push is impossible (in_ready=0).
- FULL, pop -> ONE; skid moves to main and skid is cleared.
- FULL, !pop -> hold.
- out_* always show the main entry.

Flush:
- Synchronous; highest priority below reset.
- On the edge with flush=1, all entries are invalidated (occ=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0).
- Any same-cycle in_valid & in_ready is discarded.
- A same-cycle pop is still considered consumed by decode; no other effect.
- in_ready=1 in the following cycle.

Mid-operation and edge cases:
- Reset during FULL or during a stall discards all contents immediately.
- in_valid=0 cycles insert no entry; bubbles appear downstream only as out_valid=0.
- in_instr and in_pc are sampled only on push; X on the inputs while in_valid=0 must not propagate.

Test Plan:
- Reset release, idle inputs -> out_valid=0, out_instr=32'h0, out_pc=0, in_ready=1, occ=0.
- SKID=1: stream PCs 0x00, 0x04, 0x08 with out_ready=1 -> each appears exactly 1 cycle after acceptance; occ stays 1; order preserved.
- SKID=1 backpressure: out_ready=0, push 0x10 then 0x14 -> occ=2, in_ready=0, out_pc holds 0x10. Then out_ready=1 -> out_pc=0x10, then 0x14; occ drops 2 -> 1 -> 0.
- Flush while FULL, with in_valid=1 (pc 0x18) on the same edge -> next cycle occ=0, out_valid=0, out_instr=NOP, in_ready=1; 0x18 never appears.
- SKID=0: out_valid=1, toggle out_ready 0 -> 1 -> in_ready follows out_ready in the same cycle. Simultaneous push (0x20) and pop -> out_pc=0x20 next cycle.
- rst_n asserted asynchronously mid-cycle while FULL -> outputs reach reset values before the next edge; after release, the first push (0x40) appears 1 cycle later.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
// if_id_pipe_reg : IF/ID pipeline register, valid/ready, flush, optional skid
// Revision: 1.0
// ============================================================================
module if_id_pipe_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter int                 SKID      = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [1:0]         occ
);

  if (SKID != 0) begin : g_skid
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic               push, pop, ready;

    // in_ready comes straight from the state flops, never from out_ready
    assign ready = (state_q != ST_FULL);
    assign push  = in_valid & ready & ~flush;
    assign pop   = (state_q != ST_EMPTY) & out_ready;

    always_comb begin
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (push) begin
              state_d      = ST_ONE;
              main_instr_d = in_instr;
              main_pc_d    = in_pc;
            end
          end
          ST_ONE: begin
            if (push && pop) begin
              main_instr_d = in_instr;
              main_pc_d    = in_pc;
            end else if (push) begin
              state_d      = ST_FULL;
              skid_instr_d = in_instr;
              skid_pc_d    = in_pc;
            end else if (pop) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (pop) begin
              state_d      = ST_ONE;
              main_instr_d = skid_instr_q;
              main_pc_d    = skid_pc_q;
              skid_instr_d = NOP_INSTR;
              skid_pc_d    = '0;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q      <= ST_EMPTY;
        main_instr_q <= NOP_INSTR;
        main_pc_q    <= '0;
        skid_instr_q <= NOP_INSTR;
        skid_pc_q    <= '0;
      end else begin
        state_q      <= state_d;
        main_instr_q <= main_instr_d;
        main_pc_q    <= main_pc_d;
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
      end
    end

    assign in_ready  = ready;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_instr = out_valid ? main_instr_q : NOP_INSTR;
    assign out_pc    = out_valid ? main_pc_q : '0;
    assign occ       = state_q;
  end else begin : g_single
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               push, pop, ready;

    assign ready = ~valid_q | out_ready;
    assign push  = in_valid & ready & ~flush;
    assign pop   = valid_q & out_ready;

    always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (push) begin
        valid_d = 1'b1;
        instr_d = in_instr;
        pc_d    = in_pc;
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
        pc_q    <= '0;
      end else begin
        valid_q <= valid_d;
        instr_q <= instr_d;
        pc_q    <= pc_d;
      end
    end

    assign in_ready  = ready;
    assign out_valid = valid_q;
    assign out_instr = valid_q ? instr_q : NOP_INSTR;
    assign out_pc    = valid_q ? pc_q : '0;
    assign occ       = {1'b0, valid_q};
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
// tb_if_id_pipe_reg : queue-model scoreboard bench for both SKID settings
// Revision: 1.0
// ============================================================================
module tb_if_id_pipe_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_instr1, out_pc1, out_instr0, out_pc0;
  logic [1:0]  occ1, occ0;

  int checks = 0;
  int failures = 0;

  logic [63:0] q1[$];
  logic [63:0] q0[$];

  always #5 clk = ~clk;

  if_id_pipe_reg #(.INSTR_W(32), .PC_W(32), .SKID(1), .NOP_INSTR(32'h0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid1),
    .out_ready(out_ready), .out_instr(out_instr1), .out_pc(out_pc1), .occ(occ1));

  if_id_pipe_reg #(.INSTR_W(32), .PC_W(32), .SKID(0), .NOP_INSTR(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid0),
    .out_ready(out_ready), .out_instr(out_instr0), .out_pc(out_pc0), .occ(occ0));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded FIFO. Depth 2 with registered ready for SKID=1,
  // depth 1 with pass-through ready for SKID=0; flush empties it.
  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      q0.delete();
    end else begin
      int  sz;
      bit  rdy, pop;
      sz  = q1.size();
      rdy = (sz < 2);
      check("s1_out_valid", 64'(out_valid1), 64'(sz != 0));
      check("s1_occ", 64'(occ1), 64'(sz));
      check("s1_in_ready", 64'(in_ready1), 64'(rdy));
      check("s1_out_instr", 64'(out_instr1), (sz != 0) ? 64'(q1[0][63:32]) : 64'h0);
      check("s1_out_pc", 64'(out_pc1), (sz != 0) ? 64'(q1[0][31:0]) : 64'h0);
      pop = (sz != 0) && out_ready;
      if (flush) q1.delete();
      else begin
        if (pop) void'(q1.pop_front());
        if (in_valid && rdy) q1.push_back({in_instr, in_pc});
      end

      sz  = q0.size();
      rdy = (sz == 0) || out_ready;
      check("s0_out_valid", 64'(out_valid0), 64'(sz != 0));
      check("s0_occ", 64'(occ0), 64'(sz));
      check("s0_in_ready", 64'(in_ready0), 64'(rdy));
      check("s0_out_instr", 64'(out_instr0), (sz != 0) ? 64'(q0[0][63:32]) : 64'h0);
      check("s0_out_pc", 64'(out_pc0), (sz != 0) ? 64'(q0[0][31:0]) : 64'h0);
      pop = (sz != 0) && out_ready;
      if (flush) q0.delete();
      else begin
        if (pop) void'(q0.pop_front());
        if (in_valid && rdy) q0.push_back({in_instr, in_pc});
      end
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input bit iv, input logic [31:0] pc, input bit fl, input bit ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_pc     = iv ? pc : 32'hx;
    in_instr  = iv ? (32'hA500_0000 | pc) : 32'hx;
    flush     = fl;
    out_ready = ordy;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("idle_out_valid", 64'(out_valid1), 64'h0);
    check("idle_out_instr", 64'(out_instr1), 64'h0);
    check("idle_out_pc", 64'(out_pc1), 64'h0);
    check("idle_in_ready", 64'(in_ready1), 64'h1);
    check("idle_occ", 64'(occ1), 64'h0);

    // Streaming with decode always ready
    drive(1, 32'h00, 0, 1);
    drive(1, 32'h04, 0, 1);
    check("stream_pc0", 64'(out_pc1), 64'h00);
    drive(1, 32'h08, 0, 1);
    check("stream_pc1", 64'(out_pc1), 64'h04);
    check("stream_occ", 64'(occ1), 64'h1);
    drive(0, 0, 0, 1);
    check("stream_pc2", 64'(out_pc1), 64'h08);
    drive(0, 0, 0, 0);

    // Backpressure fills the skid entry, then drains in order
    drive(1, 32'h10, 0, 0);
    drive(1, 32'h14, 0, 0);
    drive(0, 0, 0, 0);
    check("bp_occ", 64'(occ1), 64'h2);
    check("bp_in_ready", 64'(in_ready1), 64'h0);
    check("bp_out_pc", 64'(out_pc1), 64'h10);
    drive(0, 0, 0, 0);
    check("bp_hold_pc", 64'(out_pc1), 64'h10);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    check("drain_pc", 64'(out_pc1), 64'h14);
    check("drain_occ", 64'(occ1), 64'h1);
    drive(0, 0, 0, 0);
    check("drained_occ", 64'(occ1), 64'h0);

    // Flush while full with a same-cycle incoming instruction
    drive(1, 32'h10, 0, 0);
    drive(1, 32'h14, 0, 0);
    drive(1, 32'h18, 1, 0);
    drive(0, 0, 0, 1);
    check("flush_occ", 64'(occ1), 64'h0);
    check("flush_out_valid", 64'(out_valid1), 64'h0);
    check("flush_out_instr", 64'(out_instr1), 64'h0);
    check("flush_in_ready", 64'(in_ready1), 64'h1);
    drive(0, 0, 0, 1);
    check("flush_no_0x18", 64'(out_valid1), 64'h0);

    // SKID=0: in_ready tracks out_ready combinationally while holding
    drive(1, 32'h1C, 0, 0);
    drive(0, 0, 0, 0);
    #1 check("s0_rdy_low", 64'(in_ready0), 64'h0);
    out_ready = 1'b1;
    #1 check("s0_rdy_high", 64'(in_ready0), 64'h1);
    in_valid = 1'b1; in_pc = 32'h20; in_instr = 32'hA500_0020;
    drive(0, 0, 0, 0);
    check("s0_push_pop_pc", 64'(out_pc0), 64'h20);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);

    // Asynchronous reset while full
    drive(1, 32'h30, 0, 0);
    drive(1, 32'h34, 0, 0);
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_occ", 64'(occ1), 64'h0);
    check("arst_out_valid", 64'(out_valid1), 64'h0);
    check("arst_out_pc", 64'(out_pc1), 64'h0);
    check("arst_out_instr", 64'(out_instr1), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 32'h40, 0, 1);
    drive(0, 0, 0, 1);
    check("post_rst_valid", 64'(out_valid1), 64'h1);
    check("post_rst_pc", 64'(out_pc1), 64'h40);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
